// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, lock state type and counter helper
package vga_pkg;
  localparam int H_ACT   = 640;
  localparam int V_ACT   = 480;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int H_SYNC  = 96;
  localparam int V_SYNC  = 2;
  localparam int AW      = 19;
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return &v ? v : v + 10'd1;
  endfunction
endpackage

// File: rtl/vga_edge_det.sv
// vga_edge_det: registers a 1-bit input and flags its rising/falling edges
module vga_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic r_q, r_prev;
  // input sample plus one cycle of history for edge detection
  always_ff @(posedge clk)
    if (rst) {r_q, r_prev} <= 2'b00;
    else {r_q, r_prev} <= {i_d, r_q};
  assign o_q    = r_q;
  assign o_rise = r_q & ~r_prev;
  assign o_fall = r_prev & ~r_q;
endmodule

// File: rtl/vga_sync_capture.sv
// vga_sync_capture: measures VGA timing, locks, and emits frame-buffer writes per active pixel
module vga_sync_capture #(
  parameter int H_ACT       = vga_pkg::H_ACT,
  parameter int V_ACT       = vga_pkg::V_ACT,
  parameter int DW          = 12,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   active_in,
  input  logic [DW-1:0]          pix_in,
  output logic                   wr_en,
  output logic [vga_pkg::AW-1:0] wr_addr,
  output logic [DW-1:0]          wr_data,
  output logic [8:0]             row,
  output logic [9:0]             col,
  output logic                   frame_start,
  output logic                   locked,
  output logic [9:0]             h_total,
  output logic [9:0]             v_total,
  output logic                   err_overrun,
  output logic                   err_lost
);
  import vga_pkg::*;
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0] L_HACT = 10'(H_ACT);
  localparam logic [8:0] L_VACT = 9'(V_ACT);
  logic w_hs_q, w_hs_rise, w_hfall, w_vs_q, w_vs_rise, w_vfall;
  logic w_act, w_act_rise, w_act_fall, w_unused;
  logic w_timeout, w_drop, w_match, w_in_range, w_wr;
  logic [9:0] w_h_new, w_h_cur, w_col;
  logic [9:0] r_hcnt, r_vcnt, r_h_ref, r_v_ref, r_col;
  logic [8:0] r_row;
  logic [DW-1:0] r_pix;
  logic [MW-1:0] r_match;
  state_t r_state;
  vga_edge_det u_hs (.clk(clk), .rst(rst), .i_d(hsync_in), .o_q(w_hs_q), .o_rise(w_hs_rise), .o_fall(w_hfall));
  vga_edge_det u_vs (.clk(clk), .rst(rst), .i_d(vsync_in), .o_q(w_vs_q), .o_rise(w_vs_rise), .o_fall(w_vfall));
  vga_edge_det u_act (.clk(clk), .rst(rst), .i_d(active_in), .o_q(w_act), .o_rise(w_act_rise), .o_fall(w_act_fall));
  assign w_unused   = &{w_hs_q, w_hs_rise, w_vs_q, w_vs_rise};
  assign w_h_new    = sat_inc(r_hcnt);
  assign w_h_cur    = w_hfall ? w_h_new : h_total;
  assign w_timeout  = ~w_hfall & (r_hcnt == 10'(TIMEOUT - 1));
  assign w_drop     = (r_state == LOCKED) & (w_timeout | (w_hfall & (w_h_new != h_total)) | (w_vfall & (r_vcnt != v_total)));
  assign w_match    = (w_h_cur == r_h_ref) & (r_vcnt == r_v_ref);
  assign w_col      = w_act_rise ? 10'd0 : w_act ? sat_inc(r_col) : r_col;
  assign w_in_range = (w_col < L_HACT) & (r_row < L_VACT);
  assign w_wr       = locked & ~w_drop & w_act & w_in_range;
  assign row        = r_row;
  assign col        = r_col;
  // line and frame length measurement; a vfall on an hfall restarts vcnt at 0
  always_ff @(posedge clk)
    if (rst) begin
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      h_total     <= '0;
      v_total     <= '0;
      frame_start <= 1'b0;
    end else begin
      r_hcnt      <= w_hfall ? 10'd0 : w_h_new;
      r_vcnt      <= w_vfall ? 10'd0 : w_hfall ? sat_inc(r_vcnt) : r_vcnt;
      h_total     <= w_hfall ? w_h_new : h_total;
      v_total     <= w_vfall ? r_vcnt : v_total;
      frame_start <= w_vfall;
    end
  // lock FSM: frame-to-frame comparison to acquire, any timing change or timeout to lose
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= SEARCH;
      r_match  <= '0;
      r_h_ref  <= '0;
      r_v_ref  <= '0;
      locked   <= 1'b0;
      err_lost <= 1'b0;
    end else begin
      if (w_vfall) begin
        r_h_ref <= w_h_cur;
        r_v_ref <= r_vcnt;
      end
      if (w_timeout | w_drop) begin
        r_state  <= SEARCH;
        locked   <= 1'b0;
        err_lost <= 1'b1;
      end else
        case (r_state)
          SEARCH:
            if (w_vfall) begin
              r_state <= MEASURE;
              r_match <= '0;
            end
          MEASURE:
            if (w_vfall) begin
              if (w_match && int'(r_match) + 1 >= LOCK_FRAMES - 1) begin
                r_state <= LOCKED;
                locked  <= 1'b1;
              end
              r_match <= w_match ? r_match + MW'(1) : '0;
            end
          LOCKED: r_state <= LOCKED;
          default: r_state <= SEARCH;
        endcase
    end
  // pixel position tracking and registered frame-buffer write port
  always_ff @(posedge clk)
    if (rst) begin
      r_pix       <= '0;
      r_col       <= '0;
      r_row       <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      err_overrun <= 1'b0;
    end else begin
      r_pix       <= pix_in;
      r_col       <= w_col;
      r_row       <= w_vfall ? 9'd0 : (w_act_fall & ~&r_row) ? r_row + 9'd1 : r_row;
      wr_en       <= w_wr;
      wr_addr     <= {r_row, w_col};
      wr_data     <= r_pix;
      err_overrun <= err_overrun | (locked & ~w_drop & w_act & ~w_in_range);
    end
endmodule

// File: tb/tb_vga_sync_capture.sv
// tb_vga_sync_capture: directed scaled-timing checks of lock, capture, overrun, loss and reset
module tb_vga_sync_capture;
  localparam int HA = 16, VA = 8, HT = 40, VT = 14;
  logic clk = 1'b0, rst, hsync_in, vsync_in, active_in;
  logic [11:0] pix_in, wr_data;
  logic wr_en, frame_start, locked, err_overrun, err_lost;
  logic [18:0] wr_addr;
  logic [8:0] row;
  logic [9:0] col, h_total, v_total;
  int checks = 0, errors = 0, cyc = 0, wr_total = 0, frame_base = 0, act_cyc = -1;
  logic [18:0] log_addr [4096];
  logic [11:0] log_data [4096];
  int log_cyc [4096];
  vga_sync_capture #(.H_ACT(HA), .V_ACT(VA), .DW(12), .LOCK_FRAMES(2), .TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .active_in(active_in),
    .pix_in(pix_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .row(row), .col(col),
    .frame_start(frame_start), .locked(locked), .h_total(h_total), .v_total(v_total),
    .err_overrun(err_overrun), .err_lost(err_lost));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #2;
    if (wr_en) begin
      if (wr_total < 4096) begin
        log_addr[wr_total] = wr_addr;
        log_data[wr_total] = wr_data;
        log_cyc[wr_total]  = cyc;
      end
      wr_total++;
    end
  end
  function automatic logic [127:0] outs();
    return {wr_en, wr_addr, wr_data, row, col, frame_start, locked, h_total, v_total, err_overrun, err_lost};
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic drive_line(input int l, input int len, input int alen);
    for (int p = 0; p < len; p++) begin
      hsync_in  = (p >= 4);
      vsync_in  = !((l == 0 && p >= 2) || l == 1 || (l == 2 && p < 2));
      active_in = (l >= 4 && l < 4 + VA && p >= 8 && p < 8 + alen);
      pix_in    = active_in ? 12'((p - 8) & 15) : 12'd0;
      if (active_in && act_cyc < 0) act_cyc = cyc;
      @(negedge clk);
    end
  endtask
  task automatic drive_frame(input int long_line);
    frame_base = wr_total;
    act_cyc = -1;
    for (int l = 0; l < VT; l++) drive_line(l, HT, l == long_line ? HA + 10 : HA);
  endtask
  task automatic check_frame(input string tag, input int n);
    chk({tag, "_count"}, 128'(wr_total - frame_base), 128'(n));
    for (int i = 0; i < n && frame_base + i < 4096; i++)
      chk({tag, "_pix"}, {log_addr[frame_base + i], log_data[frame_base + i]},
          {9'(i / HA), 10'(i % HA), 12'(i % HA)});
  endtask
  initial begin
    rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; active_in = 1'b0; pix_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), '0);
    rst = 1'b0;
    drive_frame(-1);
    chk("f1_locked", locked, 0);
    check_frame("f1", 0);
    drive_frame(-1);
    chk("f2_locked", locked, 0);
    drive_frame(-1);
    chk("f3_locked", locked, 1);
    chk("h_total", h_total, HT);
    chk("v_total", v_total, VT);
    check_frame("f3", HA * VA);
    drive_frame(-1);
    check_frame("f4", HA * VA);
    chk("latency", 128'(log_cyc[frame_base]), 128'(act_cyc + 2));
    chk("last_addr", log_addr[frame_base + HA * VA - 1], {9'(VA - 1), 10'(HA - 1)});
    chk("overrun_clear", err_overrun, 0);
    chk("lost_clear", err_lost, 0);
    drive_frame(5);
    check_frame("overrun_frame", HA * VA);
    chk("overrun_set", err_overrun, 1);
    chk("overrun_locked", locked, 1);
    for (int l = 0; l < 6; l++) drive_line(l, HT, HA);
    drive_line(6, 12, HA);
    rst = 1'b1;
    @(negedge clk);
    chk("midline_reset_outs", outs(), '0);
    rst = 1'b0;
    for (int l = 7; l < VT; l++) drive_line(l, HT, HA);
    drive_frame(-1);
    chk("x1_locked", locked, 0);
    drive_frame(-1);
    chk("x2_locked", locked, 0);
    drive_frame(-1);
    chk("x3_locked", locked, 1);
    check_frame("x3", HA * VA);
    hsync_in = 1'b1; vsync_in = 1'b1; active_in = 1'b0;
    repeat (900) @(negedge clk);
    chk("pre_timeout_locked", locked, 1);
    chk("pre_timeout_lost", err_lost, 0);
    repeat (200) @(negedge clk);
    chk("timeout_locked", locked, 0);
    chk("timeout_lost", err_lost, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lost_cleared", err_lost, 0);
    repeat (3) drive_frame(-1);
    chk("e_locked", locked, 1);
    frame_base = wr_total;
    drive_line(0, HT, HA);
    drive_line(1, HT, HA);
    chk("before_short_locked", locked, 1);
    drive_line(2, HT - 10, HA);
    chk("short_line_locked", locked, 1);
    drive_line(3, HT, HA);
    chk("drop_locked", locked, 0);
    chk("drop_lost", err_lost, 1);
    for (int l = 4; l < VT; l++) drive_line(l, HT, HA);
    check_frame("drop_frame", 0);
    drive_frame(-1);
    chk("relock1_locked", locked, 0);
    check_frame("relock1", 0);
    drive_frame(-1);
    chk("relock2_locked", locked, 1);
    check_frame("relock2", HA * VA);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
